int_to_fp: RTL and testbench

INT_TO_FP -- requirements
Module: int_to_fp

---
 rtl/fp_pkg.sv | 32 +++
 rtl/fp_round.sv | 44 ++++
 rtl/int_to_fp.sv | 121 ++++++++++++
 tb/tb_int_to_fp.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared single-precision field widths, exponent constants and
//                the sequencer state encoding for the FP conversion blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

  // IEEE 754 single-precision field widths
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  // Exponent bias and the exponent of an unnormalised 32-bit integer whose
  // binary point sits just right of bit 31
  localparam int EXP_BIAS    = 127;
  localparam int EXP_INT_TOP = EXP_BIAS + 31;

  // Conversion sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage : fp_pkg

`default_nettype wire

// File: rtl/fp_round.sv
// ============================================================================
//  Module      : fp_round
//  Description : Combinational rounding of a normalised 32-bit magnitude
//                (bit 31 = hidden one) into a 23-bit mantissa and exponent.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round
  import fp_pkg::*;
#(
  parameter bit RNE = 1'b1
) (
  input  logic [31:0]       mag_i,
  input  logic [EXP_W-1:0]  exp_i,
  output logic [MANT_W-1:0] mant_o,
  output logic [EXP_W-1:0]  exp_o
);

  logic [MANT_W-1:0] w_mant;
  logic              w_guard;
  logic              w_sticky;
  logic              w_inc;
  logic [MANT_W:0]   w_sum;

  // Split the magnitude, decide the increment and fold a mantissa carry into the exponent
  always_comb begin
    w_mant   = mag_i[30:8];
    w_guard  = mag_i[7];
    w_sticky = |mag_i[6:0];
    w_inc    = RNE && w_guard && (w_sticky || w_mant[0]);
    w_sum    = {1'b0, w_mant} + {{MANT_W{1'b0}}, w_inc};
    if (w_sum[MANT_W]) begin
      mant_o = '0;
      exp_o  = exp_i + 1'b1;
    end else begin
      mant_o = w_sum[MANT_W-1:0];
      exp_o  = exp_i;
    end
  end

endmodule : fp_round

`default_nettype wire

// File: rtl/int_to_fp.sv
// ============================================================================
//  Module      : int_to_fp
//  Description : Multi-cycle signed 32-bit integer to IEEE 754 single
//                conversion; one-bit-per-cycle normalisation, then rounding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_to_fp
  import fp_pkg::*;
#(
  parameter bit RNE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  state_t             state_q;
  state_t             state_d;
  logic [31:0]        a_q;
  logic [31:0]        mag_q;
  logic [EXP_W-1:0]   exp_q;
  logic [SIGN_W-1:0]  sign_q;
  logic [31:0]        result_q;
  logic               done_q;

  logic [31:0]        w_mag;
  logic [MANT_W-1:0]  w_rmant;
  logic [EXP_W-1:0]   w_rexp;

  // Absolute value of the captured operand; -2^31 maps onto 0x80000000
  assign w_mag = a_q[31] ? (~a_q + 32'd1) : a_q;

  fp_round #(
    .RNE (RNE)
  ) u_round (
    .mag_i  (mag_q),
    .exp_i  (exp_q),
    .mant_o (w_rmant),
    .exp_o  (w_rexp)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a new request restarts from CONV in any state
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = CONV;
    end else begin
      case (state_q)
        CONV:    state_d = (w_mag == 32'd0) ? DONE : NORM;
        NORM:    if (mag_q[31]) state_d = ROUND;
        ROUND:   state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath: operand capture, one-bit normalisation shift, result load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      mag_q    <= '0;
      exp_q    <= '0;
      sign_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        CONV: begin
          if (w_mag == 32'd0) begin
            result_q <= '0;
            done_q   <= 1'b1;
          end else begin
            mag_q  <= w_mag;
            exp_q  <= EXP_W'(EXP_INT_TOP);
            sign_q <= a_q[31];
          end
        end
        NORM: begin
          if (!mag_q[31]) begin
            mag_q <= {mag_q[30:0], 1'b0};
            exp_q <= exp_q - 1'b1;
          end
        end
        ROUND: begin
          result_q <= {sign_q, w_rexp, w_rmant};
          done_q   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs: busy spans the working states, result/done come from registers
  always_comb begin
    busy   = (state_q == CONV) || (state_q == NORM) || (state_q == ROUND);
    result = result_q;
    done   = done_q;
  end

endmodule : int_to_fp

`default_nettype wire

// File: tb/tb_int_to_fp.sv
// ============================================================================
//  Module      : tb_int_to_fp
//  Description : Scoreboard bench for int_to_fp (round-to-nearest-even and
//                truncating instances driven in parallel).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_to_fp;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic [31:0] result_t;
  logic        done_t;
  logic        busy_t;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [31:0] op;
    logic [31:0] exp_rne;
    logic [31:0] exp_trn;
    int          lat;
  } sb_entry_t;

  sb_entry_t sb[$];

  logic [31:0] last_res;
  logic [31:0] last_res_t;
  int          last_lat;

  int_to_fp #(.RNE(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  int_to_fp #(.RNE(1'b0)) dut_trn (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .result (result_t),
    .done   (done_t),
    .busy   (busy_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference conversion: locate the MSB, shift into a 24-bit significand,
  // and round on the discarded remainder
  function automatic logic [31:0] ref_conv(input logic [31:0] op, input bit rne);
    logic        s;
    logic [31:0] mag;
    logic [32:0] m;
    logic [31:0] rem;
    logic [31:0] half;
    int          p;
    int          sh;
    int          e;
    s   = op[31];
    mag = s ? (~op + 32'd1) : op;
    if (mag == 32'd0) return 32'd0;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    e = 127 + p;
    if (p <= 23) begin
      m = {1'b0, mag} << (23 - p);
    end else begin
      sh   = p - 23;
      m    = {1'b0, mag >> sh};
      rem  = mag & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rne && ((rem > half) || ((rem == half) && m[0]))) m = m + 33'd1;
      if (m[24]) begin
        m = m >> 1;
        e = e + 1;
      end
    end
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] op);
    logic [31:0] mag;
    int          p;
    mag = op[31] ? (~op + 32'd1) : op;
    if (mag == 32'd0) return 1;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    return 3 + (31 - p);
  endfunction

  // Issue one request, wait (bounded) for done, then score it
  task automatic run_conv(input logic [31:0] op);
    sb_entry_t e;
    int        lat;
    bit        got;
    @(negedge clk);
    start = 1'b1;
    a     = op;
    e.op      = op;
    e.exp_rne = ref_conv(op, 1'b1);
    e.exp_trn = ref_conv(op, 1'b0);
    e.lat     = ref_lat(op);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("done_cleared", {31'd0, done}, 32'd0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1'b1;
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("result_rne", result, e.exp_rne);
      check("result_trn", result_t, e.exp_trn);
      check("done_trn", {31'd0, done_t}, 32'd1);
      check("latency", 32'(lat), 32'(e.lat));
    end
    last_res   = result;
    last_res_t = result_t;
    last_lat   = lat;
  endtask

  initial begin
    bit          seen;
    logic [31:0] op;
    int          lat;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    start   = 1'b1;
    a       = 32'd5;

    // Reset wins over a simultaneous start
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;

    // Directed corner values
    run_conv(32'd1);
    check("a1_res", last_res, 32'h3F80_0000);
    check("a1_lat", 32'(last_lat), 32'd34);
    run_conv(32'hFFFF_FFFF);
    check("m1_res", last_res, 32'hBF80_0000);
    run_conv(32'h8000_0000);
    check("min_res", last_res, 32'hCF00_0000);
    check("min_lat", 32'(last_lat), 32'd3);
    run_conv(32'h7FFF_FFFF);
    check("max_rne", last_res, 32'h4F00_0000);
    check("max_trn", last_res_t, 32'h4EFF_FFFF);
    run_conv(32'h0100_0001);
    check("tie_even", last_res, 32'h4B80_0000);
    run_conv(32'h0100_0003);
    check("round_up", last_res, 32'h4B80_0002);

    // Zero: one-edge latency, then done holds and busy stays low
    run_conv(32'd0);
    check("zero_res", last_res, 32'd0);
    check("zero_lat", 32'(last_lat), 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("zero_busy_low", {31'd0, busy}, 32'd0);
      check("zero_done_hold", {31'd0, done}, 32'd1);
    end

    // Restart: second start 5 edges after the first discards the first
    @(negedge clk);
    start = 1'b1;
    a     = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("restart_no_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    start = 1'b1;
    a     = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
    end
    check("restart_done", {31'd0, seen}, 32'd1);
    check("restart_res", result, 32'h4000_0000);
    check("restart_lat", 32'(lat), 32'd33);

    // Reset at edge 10 of a long conversion: nothing completes afterwards
    @(negedge clk);
    start = 1'b1;
    a     = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", {31'd0, seen}, 32'd0);
    check("midrst_res_zero", result, 32'd0);

    // Randomised sweep; occasional right shifts exercise long normalisation
    for (int i = 0; i < 10000; i++) begin
      op = $urandom;
      if ($urandom_range(0, 15) == 0) op = op >> $urandom_range(0, 31);
      run_conv(op);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_int_to_fp

`default_nettype wire
